// File: rtl/wb_timer.sv
// Wishbone timer: prescaled 32-bit up-counter, compare with optional auto-reload, sticky MATCH, level irq.
// Every request gets an ack/err exactly one cycle after acceptance; wb_stall_o is tied low.
module wb_timer #(
    parameter  int DataWidth = 32,
    parameter  int AddrWidth = 30,
    localparam int SelWidth  = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DataWidth-1:0] wb_data_i,
    input  logic [AddrWidth-1:0] wb_addr_i,
    input  logic [SelWidth-1:0]  wb_sel_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    output logic [DataWidth-1:0] wb_data_o,
    output logic                 wb_ack_o,
    output logic                 wb_stall_o,
    output logic                 wb_err_o,
    output logic                 irq_o
);

    logic [2:0]           r_ctrl;
    logic [15:0]          r_prescale;
    logic [15:0]          r_pc;
    logic [DataWidth-1:0] r_count;
    logic [DataWidth-1:0] r_compare;
    logic                 r_match;
    logic                 r_ack;
    logic                 r_err;
    logic [DataWidth-1:0] r_data;

    logic                 w_req;
    logic                 w_wr;
    logic [2:0]           w_off;
    logic                 w_mapped;
    logic [DataWidth-1:0] w_bmask;
    logic [DataWidth-1:0] w_rdata;
    logic                 w_wr_ctrl;
    logic                 w_wr_pre;
    logic                 w_wr_count;
    logic                 w_wr_cmp;
    logic                 w_wr_stat;
    logic                 w_tick;
    logic [DataWidth-1:0] w_next;
    logic                 w_hit;
    logic                 w_clr;
    logic                 w_unused;

    assign w_unused   = ^wb_addr_i[AddrWidth-1:3];
    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_wr       = w_req & wb_we_i;
    assign w_off      = wb_addr_i[2:0];
    assign w_mapped   = (w_off <= 3'd4);
    assign w_wr_ctrl  = w_wr && (w_off == 3'd0);
    assign w_wr_pre   = w_wr && (w_off == 3'd1);
    assign w_wr_count = w_wr && (w_off == 3'd2);
    assign w_wr_cmp   = w_wr && (w_off == 3'd3);
    assign w_wr_stat  = w_wr && (w_off == 3'd4);

    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < SelWidth; i++) begin
            w_bmask[i*8 +: 8] = {8{wb_sel_i[i]}};
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            3'd0:    w_rdata = {{(DataWidth-3){1'b0}}, r_ctrl};
            3'd1:    w_rdata = {{(DataWidth-16){1'b0}}, r_prescale};
            3'd2:    w_rdata = r_count;
            3'd3:    w_rdata = r_compare;
            3'd4:    w_rdata = {{(DataWidth-1){1'b0}}, r_match};
            default: w_rdata = '0;
        endcase
    end

    // A bus write to COUNT suppresses match evaluation for that tick.
    assign w_tick = r_ctrl[0] && (r_pc == r_prescale);
    assign w_next = r_count + 1'b1;
    assign w_hit  = w_tick && !w_wr_count && (w_next == r_compare);
    assign w_clr  = w_wr_stat && wb_sel_i[0] && wb_data_i[0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pc       <= '0;
            r_count    <= '0;
            r_compare  <= '1;
            r_match    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
        end else begin
            r_ack  <= w_req & w_mapped;
            r_err  <= w_req & ~w_mapped;
            r_data <= (w_req && w_mapped && !wb_we_i) ? w_rdata : '0;

            if (w_wr_ctrl && wb_sel_i[0]) begin
                r_ctrl <= wb_data_i[2:0];
            end
            if (w_wr_pre) begin
                r_prescale <= (r_prescale & ~w_bmask[15:0]) | (wb_data_i[15:0] & w_bmask[15:0]);
            end
            if (w_wr_pre || !r_ctrl[0] || w_tick) begin
                r_pc <= '0;
            end else begin
                r_pc <= r_pc + 16'd1;
            end

            if (w_wr_count) begin
                r_count <= (r_count & ~w_bmask) | (wb_data_i & w_bmask);
            end else if (w_tick) begin
                r_count <= (w_hit && r_ctrl[1]) ? '0 : w_next;
            end
            if (w_wr_cmp) begin
                r_compare <= (r_compare & ~w_bmask) | (wb_data_i & w_bmask);
            end

            // A match set beats a same-cycle write-1-to-clear.
            r_match <= w_hit | (r_match & ~w_clr);
        end
    end

    assign wb_data_o  = r_data;
    assign wb_ack_o   = r_ack;
    assign wb_err_o   = r_err;
    assign wb_stall_o = 1'b0;
    assign irq_o      = r_match & r_ctrl[2];

endmodule

// File: tb/tb_wb_timer.sv
// Randomized scoreboard bench for wb_timer against a cycle-level reference model of the register map.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_data_i;
    logic [29:0] wb_addr_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_data_o;
    logic        wb_ack_o, wb_stall_o, wb_err_o, irq_o;

    wb_timer dut (
        .clk_i(clk), .reset_i(rst),
        .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
        .wb_err_o(wb_err_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          stamp;
        bit          ack;
        bit          err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference model state (value after the most recent clock edge).
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    int          m_pc;
    logic [31:0] m_count, m_cmp;
    bit          m_match;

    // Request driven into the upcoming edge, applied to the model once that edge has passed.
    bit          p_vld, p_we;
    int          p_off;
    logic [31:0] p_dat;
    logic [3:0]  p_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 3'd0; m_pre = 16'd0; m_pc = 0;
        m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0;
        p_vld = 1'b0; p_we = 1'b0; p_off = 0; p_dat = 32'd0; p_sel = 4'd0;
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = nw[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0:       return {29'd0, m_ctrl};
            1:       return {16'd0, m_pre};
            2:       return m_count;
            3:       return m_cmp;
            4:       return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit          tick, set, wr;
        logic [31:0] nxt, tmp;
        tick = m_ctrl[0] && (m_pc == int'(m_pre));
        wr   = p_vld && p_we;
        set  = 1'b0;
        if (tick && !(wr && p_off == 2)) begin
            nxt = m_count + 32'd1;
            if (nxt == m_cmp) begin
                set = 1'b1;
                m_count = m_ctrl[1] ? 32'd0 : nxt;
            end else begin
                m_count = nxt;
            end
        end
        m_pc = (!m_ctrl[0] || tick) ? 0 : m_pc + 1;
        if (wr) begin
            case (p_off)
                0: if (p_sel[0]) m_ctrl = p_dat[2:0];
                1: begin
                    tmp  = lanes({16'd0, m_pre}, p_dat, p_sel);
                    m_pre = tmp[15:0];
                    m_pc  = 0;
                end
                2: m_count = lanes(m_count, p_dat, p_sel);
                3: m_cmp   = lanes(m_cmp, p_dat, p_sel);
                4: if (p_sel[0] && p_dat[0]) m_match = 1'b0;
                default: ;
            endcase
        end
        if (set) m_match = 1'b1;
    endtask

    task automatic bus(input bit vld, input bit we, input int off,
                       input logic [31:0] dat, input logic [3:0] sel);
        exp_t        e;
        logic [29:0] a;
        @(posedge clk); #1;
        model_step();
        a = $urandom();
        a[2:0] = off[2:0];
        wb_cyc_i = vld; wb_stb_i = vld; wb_we_i = we;
        wb_addr_i = a; wb_data_i = dat; wb_sel_i = sel;
        if (vld) begin
            e.stamp    = cyc_cnt;
            e.ack      = (off <= 4);
            e.err      = (off > 4);
            e.chk_data = !we;
            e.data     = model_read(off);
            sb.push_back(e);
        end
        p_vld = vld; p_we = we; p_off = off; p_dat = dat; p_sel = sel;
    endtask

    task automatic wr(input int off, input logic [31:0] dat);
        bus(1'b1, 1'b1, off, dat, 4'hF);
    endtask
    task automatic rd(input int off);
        bus(1'b1, 1'b0, off, $urandom(), 4'($urandom_range(0, 15)));
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 0, 32'd0, 4'd0);
    endtask

    // Monitor: compares responses and irq against the model, decoupled from the driver.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("irq", {31'd0, irq_o}, {31'd0, m_match & m_ctrl[2]});
                check("stall", {31'd0, wb_stall_o}, 32'd0);
                if (wb_ack_o || wb_err_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_latency", cyc_cnt, e.stamp + 1);
                        check("ack", {31'd0, wb_ack_o}, {31'd0, e.ack});
                        check("err", {31'd0, wb_err_o}, {31'd0, e.err});
                        if (e.chk_data) check("rdata", wb_data_o, e.data);
                    end
                end else begin
                    check("idle_data", wb_data_o, 32'd0);
                    if (sb.size() > 0 && sb[0].stamp + 1 <= cyc_cnt) begin
                        e = sb.pop_front();
                        check("missing_rsp", 32'd0, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, off;
        logic [31:0] d;
        rst = 1'b1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_err", {31'd0, wb_err_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        rst = 1'b0;

        // Reset values and an unmapped read.
        for (int i = 0; i < 5; i++) rd(i);
        rd(6);
        idle(2);

        // Free-running count with compare, no reload.
        wr(1, 3); wr(3, 5); wr(0, 32'h5);
        for (int i = 0; i < 40; i++) rd((i % 3 == 0) ? 4 : 2);

        // Auto-reload, then W1C traffic including clears that land in match cycles.
        wr(0, 0); wr(2, 0); wr(4, 1); wr(0, 32'h7);
        for (int i = 0; i < 40; i++) rd(2);
        wr(4, 1); rd(4);
        wr(1, 0); wr(3, 3);
        for (int i = 0; i < 12; i++) begin wr(4, 1); rd(4); end

        // Byte-lane write into a stopped counter, then wrap-around.
        wr(0, 0); wr(2, 0);
        bus(1'b1, 1'b1, 2, 32'h1234_5678, 4'b0011); rd(2);
        wr(4, 1); wr(3, 32'h10); wr(2, 32'hFFFF_FFFE); wr(0, 1);
        for (int i = 0; i < 4; i++) rd(2);
        rd(4);
        wr(0, 0); wr(3, 0); wr(2, 32'hFFFF_FFFE); wr(0, 5);
        for (int i = 0; i < 4; i++) rd(4);

        // Back-to-back compare write/read and a COUNT write on a tick.
        wr(3, 32'hCAFE_0001); rd(3);
        wr(2, 32'h0000_0ABC); rd(2); rd(2);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            r   = $urandom_range(0, 9);
            off = $urandom_range(0, 7);
            if (r == 0) idle(1);
            else if (r <= 5) rd(off);
            else begin
                case (off)
                    0: d = $urandom_range(0, 7);
                    1: d = $urandom_range(0, 3);
                    2: d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                       : $urandom_range(0, 12);
                    3: d = $urandom_range(0, 12);
                    default: d = $urandom();
                endcase
                bus(1'b1, 1'b1, off, d, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
            end
        end

        // Reset while a response is pending and the timer is firing interrupts.
        wr(1, 0); wr(4, 1); wr(2, 0); wr(3, 3); wr(0, 7);
        idle(8);
        rd(2);
        @(posedge clk); #1;
        check("ack_pending", {31'd0, wb_ack_o}, 32'd1);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        rst = 1'b1;
        #1;
        check("mid_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("mid_rst_err", {31'd0, wb_err_o}, 32'd0);
        check("mid_rst_data", wb_data_o, 32'd0);
        check("mid_rst_irq", {31'd0, irq_o}, 32'd0);
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        for (int i = 0; i < 5; i++) rd(i);
        idle(4);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
